// File: rtl/isqrt_rr_scheduler.sv
// Round-robin front end for one shared pipelined isqrt unit: grants one requester
// per cycle, tags the issue with its id, and routes each root back to its owner.

module isqrt_rr_rsp_lane (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hit,
  input  logic [15:0] i_y,
  output logic        o_vld,
  output logic [15:0] o_y
);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vld <= 1'b0;
      o_y   <= '0;
    end else begin
      o_vld <= i_hit;
      if (i_hit) o_y <= i_y;
    end
  end
endmodule

module isqrt_rr_scheduler #(
  parameter int N_REQ         = 3,
  parameter int ISQRT_LATENCY = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_vld,
  input  logic [N_REQ-1:0][31:0] i_req_x,
  output logic [N_REQ-1:0]       o_req_rdy,
  output logic                   o_isqrt_arg_vld,
  output logic [31:0]            o_isqrt_x,
  input  logic                   i_isqrt_res_vld,
  input  logic [15:0]            i_isqrt_y,
  output logic [N_REQ-1:0]       o_rsp_vld,
  output logic [N_REQ-1:0][15:0] o_rsp_y,
  output logic                   o_err
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] id;
  } tag_t;

  logic [IW-1:0]  r_ptr;
  logic           r_arg_vld;
  logic [31:0]    r_x;
  logic [IW-1:0]  r_iss_id;
  logic           r_err;
  tag_t [ISQRT_LATENCY-1:0] r_tag_pipe;

  logic [N_REQ-1:0] w_gnt;
  logic             w_gnt_any;
  logic [IW-1:0]    w_gnt_id;
  logic [IW:0]      w_idx;
  tag_t             w_tail;
  logic [N_REQ-1:0] w_hit;

  // Scan ptr, ptr+1, ... modulo N_REQ; the first valid requester wins.
  always_comb begin
    w_gnt     = '0;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(N_REQ)) w_idx = w_idx - (IW+1)'(N_REQ);
      if (!w_gnt_any && i_req_vld[w_idx[IW-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_idx[IW-1:0];
      end
    end
    w_gnt[w_gnt_id] = w_gnt_any;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr     <= '0;
      r_arg_vld <= 1'b0;
      r_x       <= '0;
      r_iss_id  <= '0;
    end else begin
      r_arg_vld <= w_gnt_any;
      r_iss_id  <= w_gnt_id;
      if (w_gnt_any) begin
        r_x   <= i_req_x[w_gnt_id];
        r_ptr <= (w_gnt_id == IW'(N_REQ-1)) ? '0 : w_gnt_id + 1'b1;
      end
    end
  end

  // Tag shadow of the isqrt pipeline; the tail lines up with i_isqrt_res_vld.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag_pipe <= '0;
    end else begin
      r_tag_pipe[0] <= '{vld: r_arg_vld, id: r_iss_id};
      for (int s = 1; s < ISQRT_LATENCY; s++) r_tag_pipe[s] <= r_tag_pipe[s-1];
    end
  end

  assign w_tail = r_tag_pipe[ISQRT_LATENCY-1];

  always_comb begin
    w_hit = '0;
    for (int k = 0; k < N_REQ; k++)
      w_hit[k] = i_isqrt_res_vld & w_tail.vld & (w_tail.id == IW'(k));
  end

  // Any disagreement between the result strobe and the tag tail is sticky.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_err <= 1'b0;
    else       r_err <= r_err | (i_isqrt_res_vld ^ w_tail.vld);
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    isqrt_rr_rsp_lane u_lane (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_hit (w_hit[g]),
      .i_y   (i_isqrt_y),
      .o_vld (o_rsp_vld[g]),
      .o_y   (o_rsp_y[g])
    );
  end

  assign o_req_rdy       = w_gnt;
  assign o_isqrt_arg_vld = r_arg_vld;
  assign o_isqrt_x       = r_x;
  assign o_err           = r_err;
endmodule
